// File: rtl/frame_buffer_if.sv
// Port bundle between the pixel producer / scan-out side and frame_buffer.
// master drives the write strobe and both addresses; slave returns q and busy.
interface frame_buffer_if #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 13
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] q;
    logic                  busy;

    modport master (
        output we, write_addr, data, read_addr,
        input  q, busy
    );

    modport slave (
        input  we, write_addr, data, read_addr,
        output q, busy
    );
endinterface

// File: rtl/frame_buffer.sv
// Simple dual-port pixel store with a registered, read-old-data read port.
// Optional post-reset zero fill: define FRAMEBUFFER_CLEAR_ON_RESET_EN.
module frame_buffer #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input logic           clk,
    input logic           reset,
    frame_buffer_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] q_r;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_in_range;
    logic                  rd_in_range;

    assign wr_in_range = {1'b0, bus.write_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, bus.read_addr} < DEPTH_W;

`ifdef FRAMEBUFFER_CLEAR_ON_RESET_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // The clear borrows the single write port so the array stays one BRAM.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        busy          = 1'b0;
        wr_en         = bus.we && wr_in_range;
        wr_addr       = bus.write_addr;
        wr_data       = bus.data;
        if (state == ST_CLEAR) begin
            busy          = 1'b1;
            wr_en         = 1'b1;
            wr_addr       = clr_addr;
            wr_data       = '0;
            clr_addr_next = clr_addr + 1'b1;
            if (clr_addr == LAST_ADDR) begin
                state_next    = ST_RUN;
                clr_addr_next = '0;
            end
        end
    end
`else
    always_comb begin
        busy    = 1'b0;
        wr_en   = bus.we && wr_in_range;
        wr_addr = bus.write_addr;
        wr_data = bus.data;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= '0;
        end else if (busy || !rd_in_range) begin
            q_r <= '0;
        end else begin
            q_r <= mem[bus.read_addr];
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = busy;
endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: driver pushes expected q/busy from a
// reference array model, monitor pops and compares on each falling edge.
module tb_frame_buffer;
    localparam int DW    = 3;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
`ifdef FRAMEBUFFER_CLEAR_ON_RESET_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    frame_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DW-1:0] q;
        logic          busy;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            clr_left = 0;
    int            compared = 0;
    int            mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q", 32'(bus.q), 32'(e.q));
                check("busy", 32'(bus.busy), 32'(e.busy));
            end
        end
    end

    // One clock of stimulus; the model reads before writing (old-data on collision).
    task automatic cycle(input logic w, input int wa, input int d, input int ra);
        exp_t e;
        bit   busy_before;
        bus.we         = w;
        bus.write_addr = AW'(wa);
        bus.data       = DW'(d);
        bus.read_addr  = AW'(ra);
        @(posedge clk);
        #1;
        busy_before = (clr_left > 0);
        e.q = (!busy_before && ra < DEPTH) ? ref_mem[ra] : '0;
        if (busy_before) begin
            ref_mem[DEPTH - clr_left] = '0;
            clr_left--;
        end else if (w && wa < DEPTH) begin
            ref_mem[wa] = DW'(d);
        end
        e.busy = (clr_left > 0);
        exp_q.push_back(e);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_q", 32'(bus.q), 32'd0);
        check("busy_in_reset", 32'(bus.busy), 32'(CLR));
        #1 reset = 1'b0;
        clr_left = CLR * DEPTH;
    endtask

    task automatic rand_cycle();
        cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    endtask

    task automatic wait_clear();
        int guard = 0;
        while (clr_left > 0 && guard < 100) begin
            rand_cycle();
            guard++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        reset          = 1'b1;
        bus.we         = 1'b0;
        bus.write_addr = '0;
        bus.data       = '0;
        bus.read_addr  = '0;
        #1;
        check("reset_q", 32'(bus.q), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'(CLR));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clr_left = CLR * DEPTH;
        wait_clear();

        // basic write/read and a never-written address
        cycle(1, 7, 5, 0);
        cycle(0, 0, 0, 7);
        cycle(0, 0, 0, 6);
        // read-during-write returns old data
        cycle(1, 2, 1, 0);
        cycle(1, 2, 6, 2);
        cycle(0, 0, 0, 2);
        // out-of-range write dropped, no aliasing
        cycle(1, 1, 3, 0);
        cycle(1, 13, 7, 0);
        cycle(0, 0, 0, 13);
        cycle(0, 0, 0, 1);
        // async reset while q holds 5, then contents per build
        cycle(0, 0, 0, 7);
        reset_pulse();
        wait_clear();
        cycle(0, 0, 0, 7);

`ifdef FRAMEBUFFER_CLEAR_ON_RESET_EN
        for (int a = 0; a < DEPTH; a++) cycle(1, a, 7, 0);
        reset_pulse();
        cycle(1, 3, 5, 3);
        wait_clear();
        for (int a = 0; a < DEPTH; a++) cycle(0, 0, 0, a);
        for (int a = 0; a < DEPTH; a++) cycle(1, a, 7, 0);
        reset_pulse();
        repeat (5) cycle(0, 0, 0, 0);
        reset_pulse();
        wait_clear();
        for (int a = 0; a < DEPTH; a++) cycle(0, 0, 0, a);
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) reset_pulse();
            rand_cycle();
        end
        wait_clear();
        for (int a = 0; a < 16; a++) cycle(0, 0, 0, a);

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
